// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle 32-bit DIV/DIVU unit.
package div_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  localparam logic [5:0] LAST_STEP = 6'd31;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// EX-stage to divider request/result bundle.
interface div_if
  import div_pkg::*;
();
  // Handshake: EX raises start_i with operands and holds it until it has seen
  // ready_o; result_o is valid only while ready_o is high, and dropping start_i
  // afterwards returns the divider to idle on the next edge.
  logic              signed_div_i;
  logic [REG_W-1:0]  opdata1_i;
  logic [REG_W-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [DREG_W-1:0] result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Restoring shift-subtract divider, one quotient bit per clock, {rem, quot} result.
// Signed DIV support is built only when DIV_SIGNED_EN is defined.
module div
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output div_state_e state_o
);

  div_state_e        state_q;
  logic [5:0]        cnt_q;
  logic [64:0]       w_q;
  logic [64:0]       w_step_d;
  logic [REG_W-1:0]  divisor_q;
  logic [DREG_W-1:0] result_q;
  logic              ready_q;
  logic [REG_W:0]    diff;
  logic [REG_W-1:0]  dividend_abs;
  logic [REG_W-1:0]  divisor_abs;
  logic [REG_W-1:0]  quot;
  logic [REG_W-1:0]  rem;
  logic              accept;

  assign accept = (state_q == DIV_FREE) && (bus.start_i == DivStart) && !bus.annul_i;

  // Partial remainder lives in W[64:33]; quotient bits shift in at W[0].
  assign diff     = {1'b0, w_q[63:32]} - {1'b0, divisor_q};
  assign w_step_d = diff[REG_W] ? {w_q[63:0], 1'b0}
                                : {diff[REG_W-1:0], w_q[31:0], 1'b1};

`ifdef DIV_SIGNED_EN
  logic neg_a, neg_b;
  logic neg_a_q, neg_b_q;

  assign neg_a        = bus.signed_div_i & bus.opdata1_i[REG_W-1];
  assign neg_b        = bus.signed_div_i & bus.opdata2_i[REG_W-1];
  assign dividend_abs = neg_a ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign divisor_abs  = neg_b ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
  // Quotient negates on differing signs; remainder follows the dividend.
  assign quot = (neg_a_q ^ neg_b_q) ? (~w_q[31:0] + 32'd1) : w_q[31:0];
  assign rem  = neg_a_q ? (~w_q[64:33] + 32'd1) : w_q[64:33];

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (accept) begin
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = bus.signed_div_i;
  assign dividend_abs  = bus.opdata1_i;
  assign divisor_abs   = bus.opdata2_i;
  assign quot          = w_q[31:0];
  assign rem           = w_q[64:33];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      w_q       <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (accept) begin
            if (bus.opdata2_i == '0) begin
              state_q <= DIV_BY_ZERO;
            end else begin
              state_q   <= DIV_ON;
              w_q       <= {32'b0, dividend_abs, 1'b0};
              divisor_q <= divisor_abs;
              cnt_q     <= '0;
            end
          end
        end
        DIV_BY_ZERO: begin
          w_q     <= '0;
          state_q <= DIV_END;
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            state_q <= DIV_FREE;
            cnt_q   <= '0;
          end else begin
            w_q   <= w_step_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == LAST_STEP) state_q <= DIV_END;
          end
        end
        DIV_END: begin
          if (bus.start_i == DivStop) begin
            state_q  <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end else begin
            result_q <= {rem, quot};
            ready_q  <= DivResultReady;
          end
        end
        default: state_q <= DIV_FREE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign state_o      = state_q;

endmodule
